// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache; misses fill via a byte-wide mem_ctrl port.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_EN.
module inst_cache #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 18
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_rdy,
    output logic [31:0] fetch_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_byte
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [31:2]        addr_q, addr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [1:0]         slot_q, slot_d;
    logic [23:0]        buf_q, buf_d;
    logic               fetch_rdy_q, fetch_rdy_d;
    logic [31:0]        fetch_inst_q, fetch_inst_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [INDEX_W-1:0] f_idx, a_idx;
    logic [TAG_W-1:0]   f_tag, a_tag;
    logic               hit;
    logic [1:0]         cnt_inc;
    logic               line_we;
    logic [31:0]        line_data;
    logic               unused_addr_lsb;

    assign f_idx   = fetch_addr[INDEX_W+1:2];
    assign f_tag   = fetch_addr[ADDR_W-1:INDEX_W+2];
    assign a_idx   = addr_q[INDEX_W+1:2];
    assign a_tag   = addr_q[ADDR_W-1:INDEX_W+2];
    assign hit     = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
    assign cnt_inc = cnt_q + 2'd1;
    assign unused_addr_lsb = ^fetch_addr[1:0];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        slot_d       = slot_q;
        buf_d        = buf_q;
        fetch_rdy_d  = fetch_rdy_q;
        fetch_inst_d = fetch_inst_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        line_we      = 1'b0;
        line_data    = {mem_byte, buf_q};
        if (rdy_in) begin
            fetch_rdy_d = 1'b0;
            if (flush) begin
                // Dropping pend_q discards a byte still in flight for a pre-flush grant.
                state_d   = IDLE;
                mem_req_d = 1'b0;
                pend_d    = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fetch_req) begin
                            if (hit) begin
                                fetch_inst_d = data_mem[f_idx];
                                fetch_rdy_d  = 1'b1;
                            end else begin
                                addr_d     = fetch_addr[31:2];
                                cnt_d      = 2'd0;
                                pend_d     = 1'b0;
                                mem_req_d  = 1'b1;
                                mem_addr_d = {fetch_addr[31:2], 2'b00};
                                state_d    = FILL;
                            end
                        end
                    end
                    FILL: begin
                        if (pend_q) begin
                            pend_d = 1'b0;
                            case (slot_q)
                                2'd0: buf_d[7:0]   = mem_byte;
                                2'd1: buf_d[15:8]  = mem_byte;
                                2'd2: buf_d[23:16] = mem_byte;
                                default: begin
                                    line_we        = 1'b1;
                                    valid_d[a_idx] = 1'b1;
                                    fetch_inst_d   = line_data;
                                    fetch_rdy_d    = 1'b1;
                                    state_d        = RESP;
                                end
                            endcase
                        end
                        // The byte for this grant lands next cycle in slot cnt_q.
                        if (mem_req_q && mem_gnt) begin
                            pend_d = 1'b1;
                            slot_d = cnt_q;
                            cnt_d  = cnt_inc;
                            if (cnt_q == 2'd3) mem_req_d = 1'b0;
                            else mem_addr_d = {addr_q, cnt_inc};
                        end
                    end
                    RESP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            slot_q       <= '0;
            buf_q        <= '0;
            fetch_rdy_q  <= 1'b0;
            fetch_inst_q <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            slot_q       <= slot_d;
            buf_q        <= buf_d;
            fetch_rdy_q  <= fetch_rdy_d;
            fetch_inst_q <= fetch_inst_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Tag/data storage needs no reset: valid_q gates every lookup.
    always_ff @(posedge clk_in) begin
        if (line_we) begin
            tag_mem[a_idx]  <= a_tag;
            data_mem[a_idx] <= line_data;
        end
    end

    assign fetch_rdy  = fetch_rdy_q;
    assign fetch_inst = fetch_inst_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        lookup;

    assign lookup = rdy_in && !flush && (state_q == IDLE) && fetch_req;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup) begin
            if (hit) hit_cnt_d = hit_cnt_q + 32'd1;
            else miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
